goldcrest_top: RTL and testbench
================================

// Module: goldcrest_top
// PURPOSE
//  Top of the Goldcrest tile: a minimal 8-bit accumulator CPU that holds no program memory.
//  Every instruction fetch, load and store is a transaction on an SPI bus to an external
//  serial RAM (23LC-style: READ 0x03, WRITE 0x02, 16-bit address, sequential mode).
//  Sits directly on the TinyTapeout pad ring; the bench attaches an SPI RAM model to the pins.
// PARAMETERS
//  DATA_PAGE  8'h01  high address byte for LD/ST (data address = {DATA_PAGE, imm})
//  CS_GAP     2      minimum clk cycles cs stays high between transactions
// PORTS
//  clk      in   1  system clock; all logic on rising edge
//  rst_n    in   1  asynchronous, active-high reset (asserted = 1 despite _n suffix)
//  ena      in   1  tile enable; ignored
//  ui_in    in   8  [1]=spi_miso; [7:2]=general input for IN; [0] unused
//  uo_out   out  8  [0]=halted [1]=spi_sclk [2]=spi_mosi [3]=spi_cs_n [7:4]=A[3:0]
//  uio_in   in   8  unused
//  uio_out  out  8  OUT register
//  uio_oe   out  8  constant 8'hFF
// BEHAVIOUR
//  Reset: cs_n=1, sclk=0, mosi=0, PC=0, A=0, OUT=0, halted=0; uo_out=8'h08. Async reset
//   mid-transaction forces cs_n high immediately; after release CPU refetches from PC=0.
//  SPI mode 0, MSB first, sclk=clk/2: per bit, sclk low 1 clk then high 1 clk. mosi set
//   while sclk low; miso sampled on the clk edge that drives sclk 1->0 (end of high phase).
//   sclk idles 0, mosi idles 0; cs_n falls one clk before first sclk rise, rises one clk after
//   last sclk fall, then stays high >= CS_GAP clk.
//  State machine: FETCH -> EXEC -> (MEM for LD/ST) -> FETCH; HALT is terminal until reset.
//   FETCH: cs_n low; send 0x03, addr {7'b0,PC,1'b0} (16 bits); read opcode byte then imm byte
//    (40 sclk pulses, one transaction). PC is 8-bit instruction index; PC+1 wraps 255->0.
//   EXEC (1 clk): decode opcode:
//    00 NOP; 01 LDI A=imm; 02 ADDI A=A+imm mod 256; 03 LD; 04 ST; 05 OUT OUT=A;
//    06 IN A={2'b00,ui_in[7:2]}; 07 JMP PC=imm; 08 JZ if A==0 PC=imm else PC+1;
//    09 HALT halted=1, no further SPI traffic; 0A..FF behave as NOP.
//    Non-jump instructions set PC=PC+1.
//   MEM LD: 0x03, addr {DATA_PAGE,imm}, read 8 bits into A (32 sclk pulses).
//   MEM ST: 0x02, addr {DATA_PAGE,imm}, write A (32 sclk pulses); miso ignored.
//  A updates in EXEC (or end of LD); OUT updates in EXEC of OUT; uo_out[7:4] tracks A live.
//  No pipelining; only one transaction in flight; no bus handshake beyond cs_n framing.
// TESTING
//  1 Reset: rst_n=1 for 5 clk -> uo_out=0x08, uio_out=0, uio_oe=0xFF; release -> first
//    transaction shifts 0x03,0x0000 on mosi with 40 sclk rises.
//  2 RAM {01 5A, 05 00, 09 00} -> uio_out=0x5A after 2nd EXEC; halted=1; cs_n stays 1.
//  3 RAM {01 FF, 02 02, 05 00, 09 00} -> uio_out=0x01 (wrap), uo_out[7:4]=1.
//  4 RAM {01 33, 04 10, 01 00, 03 10, 05 00, 09 00} -> write 0x33 to 0x0110 (cmd 0x02),
//    read back, uio_out=0x33.
//  5 RAM {01 00, 08 03, 01 77, 05 00, 09 00} -> JZ taken, uio_out=0x00; with first imm=01
//    JZ not taken, uio_out=0x77.
//  6 Assert rst_n during a FETCH -> cs_n=1 same cycle; after release fetch restarts at 0x0000.

Source files
------------

// File: rtl/goldcrest_top.sv
// Goldcrest tile top: an 8-bit accumulator CPU with no local program storage.
// All instruction fetches, loads and stores are SPI transactions (mode 0, MSB
// first, sclk = clk/2) to an external 23LC-style serial RAM. One transaction
// is in flight at a time; the CPU sequences FETCH -> EXEC -> (MEM) -> FETCH.
module goldcrest_top #(
    parameter logic [7:0] DATA_PAGE = 8'h01,
    parameter int         CS_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // CPU sequencing states
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;

    // Opcodes; everything not listed executes as NOP
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_LD   = 8'h03;
    localparam logic [7:0] OP_ST   = 8'h04;
    localparam logic [7:0] OP_OUT  = 8'h05;
    localparam logic [7:0] OP_IN   = 8'h06;
    localparam logic [7:0] OP_JMP  = 8'h07;
    localparam logic [7:0] OP_JZ   = 8'h08;
    localparam logic [7:0] OP_HALT = 8'h09;

    // SPI RAM commands
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Index of the last bit in a fetch (cmd+addr+2 bytes) and a load/store (cmd+addr+1 byte)
    localparam logic [5:0] LAST_FETCH = 6'd39;
    localparam logic [5:0] LAST_MEM   = 6'd31;

    // cs_n must have been high for CS_GAP cycles at the edge that drops it again;
    // gap_q counts completed high cycles before the current one.
    localparam int         GAP_M1  = (CS_GAP > 0) ? CS_GAP - 1 : 0;
    localparam logic [7:0] GAP_MIN = GAP_M1[7:0];

    // Saturating increment for the chip-select idle counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [2:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic        tail_q, tail_d;
    logic        phase_q, phase_d;
    logic [5:0]  bit_q, bit_d;
    logic [5:0]  last_q, last_d;
    logic [7:0]  gap_q, gap_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  out_q, out_d;
    logic        halted_q, halted_d;

    logic [39:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  imm_q, imm_d;

    logic        miso;
    logic        is_st;
    logic        gap_ok;
    logic [39:0] frame;

    logic        unused_ok;

    assign miso      = ui_in[1];
    assign unused_ok = ^{ena, uio_in, ui_in[0]};

    assign is_st  = (op_q == OP_ST);
    assign gap_ok = (gap_q >= GAP_MIN);

    // Outgoing frame for the transaction the current state would start
    always_comb begin
        if (state_q == ST_FETCH) begin
            frame = {CMD_READ, 7'b0, pc_q, 1'b0, 16'h0000};
        end else begin
            frame = {(is_st ? CMD_WRITE : CMD_READ), DATA_PAGE, imm_q,
                     (is_st ? a_q : 8'h00), 8'h00};
        end
    end

    // Next-state logic: SPI bit engine shared by FETCH and MEM, plus decode in EXEC
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        tail_d   = tail_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        last_d   = last_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        pc_d     = pc_q;
        a_d      = a_q;
        out_d    = out_q;
        halted_d = halted_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        op_d     = op_q;
        imm_d    = imm_q;
        gap_d    = cs_n_q ? sat_inc8(gap_q) : 8'h00;

        unique case (state_q)
            ST_FETCH, ST_MEM: begin
                if (!busy_q) begin
                    if (gap_ok) begin
                        // cs_n drops with sclk low and the first bit already on mosi
                        busy_d  = 1'b1;
                        tail_d  = 1'b0;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        bit_d   = 6'd0;
                        last_d  = (state_q == ST_FETCH) ? LAST_FETCH : LAST_MEM;
                        tx_d    = frame;
                        mosi_d  = frame[39];
                    end
                end else if (tail_q) begin
                    // One clk after the last sclk fall: release cs_n and hand off
                    cs_n_d = 1'b1;
                    busy_d = 1'b0;
                    tail_d = 1'b0;
                    if (state_q == ST_FETCH) begin
                        op_d    = rx_q[15:8];
                        imm_d   = rx_q[7:0];
                        state_d = ST_EXEC;
                    end else begin
                        if (op_q == OP_LD) begin
                            a_d = rx_q[7:0];
                        end
                        state_d = ST_FETCH;
                    end
                end else if (!phase_q) begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    // End of high phase: sample miso as sclk falls
                    sclk_d  = 1'b0;
                    phase_d = 1'b0;
                    rx_d    = {rx_q[14:0], miso};
                    if (bit_q == last_q) begin
                        tail_d = 1'b1;
                        mosi_d = 1'b0;
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        tx_d   = {tx_q[38:0], 1'b0};
                        mosi_d = tx_q[38];
                    end
                end
            end
            ST_EXEC: begin
                pc_d    = pc_q + 8'd1;
                state_d = ST_FETCH;
                unique case (op_q)
                    OP_LDI:  a_d = imm_q;
                    OP_ADDI: a_d = a_q + imm_q;
                    OP_LD:   state_d = ST_MEM;
                    OP_ST:   state_d = ST_MEM;
                    OP_OUT:  out_d = a_q;
                    OP_IN:   a_d = {2'b00, ui_in[7:2]};
                    OP_JMP:  pc_d = imm_q;
                    OP_JZ:   pc_d = (a_q == 8'h00) ? imm_q : pc_q + 8'd1;
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Control and architectural state, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_FETCH;
            busy_q   <= 1'b0;
            tail_q   <= 1'b0;
            phase_q  <= 1'b0;
            bit_q    <= 6'd0;
            last_q   <= LAST_FETCH;
            gap_q    <= 8'h00;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            pc_q     <= 8'h00;
            a_q      <= 8'h00;
            out_q    <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            tail_q   <= tail_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

    // Shift registers and fetched instruction; always written before being used
    always_ff @(posedge clk) begin
        tx_q  <= tx_d;
        rx_q  <= rx_d;
        op_q  <= op_d;
        imm_q <= imm_d;
    end

    assign uo_out  = {a_q[3:0], cs_n_q, mosi_q, sclk_q, halted_q};
    assign uio_out = out_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_goldcrest_top.sv
// Bench for goldcrest_top: a 23LC-style SPI RAM model on the pins, an
// instruction-level reference model of the CPU, directed and random programs.
module tb_goldcrest_top;

    localparam logic [7:0] DATA_PAGE = 8'h01;
    localparam int         CS_GAP    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [5:0] in_bits = 6'd0;
    logic       miso = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {in_bits, miso, 1'b0};

    goldcrest_top #(.DATA_PAGE(DATA_PAGE), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    wire sclk = uo_out[1];
    wire mosi = uo_out[2];
    wire cs_n = uo_out[3];

    int n_cmp = 0;
    int n_bad = 0;

    // Compare one observed value with its expected value
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI RAM model ----------------
    // transaction record: {cmd, addr, sclk rises, first write byte, cs_n low cycles}
    logic [7:0]  ram [0:65535];
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  wshift;
    logic [7:0]  wbyte;
    int          bcnt;
    int          low_cyc;
    logic [47:0] got_q[$];

    always @(negedge cs_n) begin
        bcnt = 0; cmd = 8'h00; addr = 16'h0000; wshift = 8'h00; wbyte = 8'h00;
    end

    always @(posedge sclk) begin
        if (!cs_n) begin
            if (bcnt < 8) cmd = {cmd[6:0], mosi};
            else if (bcnt < 24) addr = {addr[14:0], mosi};
            else if (cmd == 8'h02) begin
                wshift = {wshift[6:0], mosi};
                if ((bcnt - 24) % 8 == 7) begin
                    ram[addr + 16'((bcnt - 24) / 8)] = wshift;
                    if (bcnt < 32) wbyte = wshift;
                end
            end
            bcnt++;
        end
    end

    always @(negedge sclk) begin
        int k;
        logic [7:0] b;
        if (!cs_n && cmd == 8'h03 && bcnt >= 24) begin
            k = bcnt - 24;
            b = ram[addr + 16'(k / 8)];
            miso <= #1 b[7 - (k % 8)];
        end
    end

    always @(posedge cs_n) begin
        got_q.push_back({cmd, addr, 8'(bcnt), wbyte, 8'(low_cyc)});
    end

    // Pin monitor, sampled mid-cycle: cs_n framing length, idle levels, gap
    int   idle_bad = 0;
    int   min_gap = 1000;
    int   hi_cyc = 0;
    bit   have_rise = 0;
    logic prev_cs = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            have_rise = 0;
            prev_cs = 1'b1;
        end else begin
            if (!cs_n) begin
                if (prev_cs) begin
                    low_cyc = 1;
                    if (have_rise && hi_cyc < min_gap) min_gap = hi_cyc;
                end else low_cyc++;
            end else begin
                if (sclk || mosi) idle_bad++;
                if (!prev_cs) begin
                    have_rise = 1;
                    hi_cyc = 1;
                end else hi_cyc++;
            end
            prev_cs = cs_n;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  mm [0:65535];
    logic [47:0] exp_q[$];
    logic [7:0]  exp_a, exp_o;
    bit          exp_h;

    task automatic run_model(input logic [5:0] inb);
        logic [7:0] pc, a, o, op, imm;
        logic [15:0] da;
        int steps;
        for (int i = 0; i < 65536; i++) mm[i] = ram[i];
        exp_q.delete();
        pc = 0; a = 0; o = 0; exp_h = 0; steps = 0;
        while (!exp_h && steps < 300) begin
            exp_q.push_back({8'h03, 16'(int'(pc) * 2), 8'd40, 8'h00, 8'd81});
            op  = mm[int'(pc) * 2];
            imm = mm[int'(pc) * 2 + 1];
            da  = {DATA_PAGE, imm};
            pc  = pc + 8'd1;
            case (op)
                8'h01: a = imm;
                8'h02: a = a + imm;
                8'h03: begin
                    exp_q.push_back({8'h03, da, 8'd32, 8'h00, 8'd65});
                    a = mm[da];
                end
                8'h04: begin
                    exp_q.push_back({8'h02, da, 8'd32, a, 8'd65});
                    mm[da] = a;
                end
                8'h05: o = a;
                8'h06: a = {2'b00, inb};
                8'h07: pc = imm;
                8'h08: if (a == 8'h00) pc = imm;
                8'h09: exp_h = 1;
                default: ;
            endcase
            steps++;
        end
        exp_a = a; exp_o = o;
    endtask

    // ---------------- program helpers ----------------
    task automatic clear_prog();
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic put(input int idx, input logic [7:0] op, input logic [7:0] imm);
        ram[idx * 2] = op;
        ram[idx * 2 + 1] = imm;
    endtask

    task automatic run_test(input string nm, input logic [5:0] inb, input int abort_at);
        int diffs;
        in_bits = inb;
        run_model(inb);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val({nm, ".rst_uo"}, uo_out, 8'h08);
        check_val({nm, ".rst_uio"}, uio_out, 8'h00);
        check_val({nm, ".rst_oe"}, uio_oe, 8'hFF);
        if (abort_at > 0) begin
            @(negedge clk) rst_n = 1'b0;
            repeat (abort_at) @(negedge clk);
            check_val({nm, ".abort_busy"}, cs_n, 1'b0);
            rst_n = 1'b1;
            #1;
            check_val({nm, ".abort_csn"}, cs_n, 1'b1);
            repeat (3) @(posedge clk);
        end
        got_q.delete();
        idle_bad = 0;
        min_gap = 1000;
        @(negedge clk) rst_n = 1'b0;
        for (int c = 0; c < 6000 && !uo_out[0]; c++) @(negedge clk);
        check_val({nm, ".halted"}, uo_out[0], 1'b1);
        repeat (40) @(negedge clk);
        check_val({nm, ".out"}, uio_out, exp_o);
        check_val({nm, ".a_nib"}, uo_out[7:4], exp_a[3:0]);
        check_val({nm, ".csn_idle"}, cs_n, 1'b1);
        check_val({nm, ".ntx"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s.tx%0d", nm, i), got_q[i], exp_q[i]);
        check_val({nm, ".idle_lvl"}, idle_bad, 0);
        check_val({nm, ".gap_ok"}, min_gap >= CS_GAP, 1);
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (ram[{DATA_PAGE, 8'(i)}] !== mm[{DATA_PAGE, 8'(i)}]) diffs++;
        check_val({nm, ".ram"}, diffs, 0);
    endtask

    initial begin
        // reset values and a plain program
        clear_prog();
        put(0, 8'h01, 8'h5A); put(1, 8'h05, 8'h00); put(2, 8'h09, 8'h00);
        run_test("ldi_out", 6'h15, 0);

        // ADDI wraps modulo 256
        clear_prog();
        put(0, 8'h01, 8'hFF); put(1, 8'h02, 8'h02); put(2, 8'h05, 8'h00); put(3, 8'h09, 8'h00);
        run_test("addi_wrap", 6'h00, 0);

        // store then load back through the data page
        clear_prog();
        put(0, 8'h01, 8'h33); put(1, 8'h04, 8'h10); put(2, 8'h01, 8'h00);
        put(3, 8'h03, 8'h10); put(4, 8'h05, 8'h00); put(5, 8'h09, 8'h00);
        run_test("st_ld", 6'h00, 0);

        // JZ taken and not taken
        clear_prog();
        put(0, 8'h01, 8'h00); put(1, 8'h08, 8'h03); put(2, 8'h01, 8'h77);
        put(3, 8'h05, 8'h00); put(4, 8'h09, 8'h00);
        run_test("jz_taken", 6'h00, 0);
        put(0, 8'h01, 8'h01);
        run_test("jz_fall", 6'h00, 0);

        // IN, JMP and an undefined opcode
        clear_prog();
        put(0, 8'h06, 8'h00); put(1, 8'h07, 8'h03); put(2, 8'h01, 8'h11);
        put(3, 8'hC4, 8'h00); put(4, 8'h05, 8'h00); put(5, 8'h09, 8'h00);
        run_test("in_jmp", 6'h2B, 0);

        // reset asserted in the middle of the first fetch
        clear_prog();
        put(0, 8'h01, 8'h42); put(1, 8'h05, 8'h00); put(2, 8'h09, 8'h00);
        run_test("abort", 6'h00, 30);

        // random forward-branching programs ending in HALT
        for (int t = 0; t < 16; t++) begin
            clear_prog();
            for (int i = 0; i < 7; i++) begin
                logic [7:0] op, imm;
                op  = 8'($urandom_range(0, 11));
                if (op == 8'd11) op = 8'($urandom_range(10, 255));
                imm = 8'($urandom_range(0, 255));
                if (op == 8'h07 || op == 8'h08) imm = 8'($urandom_range(i + 1, 7));
                put(i, op, imm);
            end
            put(7, 8'h09, 8'h00);
            run_test($sformatf("rand%0d", t), 6'($urandom_range(0, 63)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
